fifo_word_tx: RTL and testbench
===============================

// Module: fifo_word_tx
// PURPOSE
//  Read side of the 16-bit word FIFO: pops words from a show-ahead FIFO (dout valid while !empty)
//  and serialises each one onto a single-wire, UART-style line: 1 start bit (0), DATA_W data bits
//  LSB first, STOP_BITS stop bits (1). Sits between the FIFO and an off-chip/debug serial link.
// PARAMETERS
//  DATA_W        16  word width, matches FIFO din/dout
//  CLKS_PER_BIT  4   clk cycles per serial bit (>=2)
//  STOP_BITS     1   number of stop bits (1 or 2)
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  rst         in   1       reset, asynchronous, active-high
//  enable      in   1       1 = allowed to start new frames
//  fifo_empty  in   1       FIFO empty flag
//  fifo_dout   in   DATA_W  FIFO head word (show-ahead)
//  fifo_rd     out  1       pop strobe to FIFO, combinational, one cycle per word
//  txd         out  1       serial line, idle high
//  busy        out  1       1 from pop cycle+1 until frame end
//  frame_done  out  1       one-cycle pulse on last cycle of final stop bit
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): state=IDLE, txd=1, busy=0, frame_done=0, counters=0,
//   shift reg=0; fifo_rd=0 while rst high. Frame in progress is abandoned, no word re-pop.
//  FSM: IDLE -> START -> DATA -> STOP -> (IDLE | START).
//  Pop: fifo_rd = enable & !fifo_empty & (state==IDLE | last cycle of final stop bit).
//   Same edge: shift reg <= fifo_dout, state <= START, bit timer <= 0. fifo_rd never high when
//   fifo_empty=1; never more than one pop per frame.
//  Bit timing: bit timer counts 0..CLKS_PER_BIT-1; each bit held exactly CLKS_PER_BIT cycles.
//   txd registered: START drives 0; DATA drives shift[0], shift right at each bit end;
//   bit index counts 0..DATA_W-1; STOP drives 1 for STOP_BITS bits.
//  Latency: fifo_rd in cycle N -> txd falls (start bit) at cycle N+1.
//  Frame length F = (1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles (72 at defaults).
//  Back-to-back: if pop condition true on final stop cycle, next START follows with zero idle
//   cycles; frame_done still pulses on that cycle; busy stays 1.
//  enable deassert mid-frame: current frame completes normally; no further pops; back to IDLE.
//  fifo_dout changing mid-frame has no effect (data captured at pop only).
//  busy=0 in IDLE; frame_done=0 except as above. txd=1 in IDLE.
// STRUCTURE
//  Package fifo_tx_pkg: state typedef (IDLE, START, DATA, STOP), TXD_IDLE=1'b1, START_BIT=1'b0.
//  One sub-module: fifo_tx_bit_timer (counter 0..CLKS_PER_BIT-1, outputs bit_end pulse,
//   sync clear on pop); FSM, shift reg and bit index stay in fifo_word_tx.
// TESTING (defaults unless noted)
//  1 Reset: rst pulse mid-DATA -> txd=1, busy=0, fifo_rd=0 immediately; no pop until rst low.
//  2 Single word 0xA5C3, enable=1, empty falls -> one fifo_rd pulse; txd = 0, then bits
//    1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first), then 1; each 4 cycles; frame_done at cycle 72.
//  3 Three words queued -> fifo_rd pulses exactly 72 cycles apart, txd never idles between
//    frames, three frame_done pulses, then IDLE with txd=1.
//  4 enable=0 with FIFO non-empty -> no fifo_rd, txd=1; drop enable at mid-frame -> frame ends,
//    no second pop.
//  5 fifo_empty=1 always -> fifo_rd never asserted over 1000 cycles; fifo_dout toggling
//    mid-frame -> transmitted bits unchanged.
//  6 CLKS_PER_BIT=2, STOP_BITS=2, word 0xFFFF -> frame 38 cycles, stop held 4 cycles.

Source files
------------

// File: rtl/fifo_tx_pkg.sv
// Shared types for the FIFO word serialiser.
// State encoding and serial line levels.
package fifo_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic TXD_IDLE  = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/fifo_word_tx_if.sv
// FIFO read side plus serial line bundle.
// slave = serialiser, master = FIFO/link side.
interface fifo_word_tx_if #(
  parameter int DATA_W = 16
);
  logic              enable;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd;
  logic              txd;
  logic              busy;
  logic              frame_done;

  modport master (
    output enable,
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd,
    input  txd,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  enable,
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd,
    output txd,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/fifo_tx_bit_timer.sv
// Serial bit timer: counts 0..CLKS_PER_BIT-1 while running.
// o_pre_end lets the caller register pulses that land on o_bit_end.
module fifo_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_run,
  output logic o_bit_end,
  output logic o_pre_end
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] r_cnt;

  assign o_bit_end = i_run & (r_cnt == LAST);
  assign o_pre_end = i_run & (r_cnt == PRE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr | o_bit_end) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fifo_word_tx.sv
// Pops words from a show-ahead FIFO and sends them
// as start + LSB-first data + stop bits on txd.
module fifo_word_tx
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input logic            clk,
  input logic            rst,
  fifo_word_tx_if.slave  bus
);
  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_W - 1);
  localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IW-1:0]     r_idx;
  logic [1:0]        r_stop;
  logic              r_txd;
  logic              r_busy;
  logic              r_done;

  logic w_bit_end;
  logic w_pre_end;
  logic w_run;
  logic w_stop_last;
  logic w_frame_end;
  logic w_pop;

  assign w_run       = (r_state != IDLE);
  assign w_stop_last = (r_state == STOP) & (r_stop == LAST_STOP);
  assign w_frame_end = w_stop_last & w_bit_end;

  // A new word may launch straight out of the final stop cycle.
  assign w_pop = ~rst & bus.enable & ~bus.fifo_empty
               & ((r_state == IDLE) | w_frame_end);

  assign bus.fifo_rd    = w_pop;
  assign bus.txd        = r_txd;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;

  fifo_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_pop),
    .i_run    (w_run),
    .o_bit_end(w_bit_end),
    .o_pre_end(w_pre_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_stop  <= '0;
      r_txd   <= TXD_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Raised one cycle early so it sits on the last stop cycle.
      r_done <= w_stop_last & w_pre_end;
      if (w_pop) begin
        r_state <= START;
        r_shift <= bus.fifo_dout;
        r_idx   <= '0;
        r_stop  <= '0;
        r_txd   <= START_BIT;
        r_busy  <= 1'b1;
      end else if (w_bit_end) begin
        unique case (r_state)
          START: begin
            r_state <= DATA;
            r_idx   <= '0;
            r_txd   <= r_shift[0];
          end
          DATA: begin
            if (r_idx == LAST_IDX) begin
              r_state <= STOP;
              r_stop  <= '0;
              r_txd   <= TXD_IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
            end
          end
          STOP: begin
            if (r_stop == LAST_STOP) begin
              r_state <= IDLE;
              r_stop  <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_stop <= r_stop + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fifo_word_tx.sv
// Bench for fifo_word_tx: FIFO model, cycle model,
// line receiver with word scoreboard, 2nd config.
module tb_fifo_word_tx;
  localparam int DW  = 16;
  localparam int CPB = 4;
  localparam int F   = (1 + DW + 1) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_word_tx_if #(.DATA_W(DW)) bus0 ();
  fifo_word_tx_if #(.DATA_W(DW)) bus1 ();

  fifo_word_tx #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  fifo_word_tx #(
    .DATA_W(DW), .CLKS_PER_BIT(2), .STOP_BITS(2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  logic [15:0] fq[$];
  logic [15:0] sb[$];
  logic [15:0] junk = '0;
  logic        l_rd;

  task automatic fifo_drive();
    bus0.fifo_empty = (fq.size() == 0);
    bus0.fifo_dout  = (fq.size() == 0) ? junk : fq[0];
  endtask

  task automatic push_word(input logic [15:0] w);
    fq.push_back(w);
    sb.push_back(w);
    fifo_drive();
  endtask

  // Each step ends 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      l_rd = bus0.fifo_rd;
      @(posedge clk);
      #1;
      if (l_rd && fq.size() > 0) void'(fq.pop_front());
      fifo_drive();
    end
  endtask

  // Cycle model of the default instance.
  bit          m_active = 0;
  int          m_cnt = 0;
  logic [15:0] m_word = '0;
  int          fd_cnt = 0;
  int          cyc = 0;
  int          pop_t[$];

  always @(negedge clk) begin
    logic e_rd;
    logic e_txd;
    int   p;
    cyc++;
    if (rst) begin
      check("rst_rd", bus0.fifo_rd, 0);
      check("rst_txd", bus0.txd, 1);
      check("rst_busy", bus0.busy, 0);
      check("rst_fd", bus0.frame_done, 0);
      m_active = 0;
    end else begin
      e_rd = bus0.enable && !bus0.fifo_empty
           && (!m_active || m_cnt == F);
      e_txd = 1'b1;
      if (m_active) begin
        p = (m_cnt - 1) / CPB;
        if (p == 0) e_txd = 1'b0;
        else if (p <= DW) e_txd = m_word[p-1];
      end
      check("rd", bus0.fifo_rd, e_rd);
      check("txd", bus0.txd, e_txd);
      check("busy", bus0.busy, m_active);
      check("fdone", bus0.frame_done,
            m_active && m_cnt == F);
      if (bus0.frame_done) fd_cnt++;
      if (bus0.fifo_rd) begin
        m_active = 1;
        m_cnt    = 1;
        m_word   = bus0.fifo_dout;
        pop_t.push_back(cyc);
      end else if (m_active) begin
        if (m_cnt == F) m_active = 0;
        else m_cnt++;
      end
    end
  end

  // Line receiver: mid-bit sampling, words go to the scoreboard.
  bit          rx_busy = 0;
  int          rx_cnt = 0;
  logic [15:0] rx_word = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (rx_busy && sb.size() > 0) void'(sb.pop_front());
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (bus0.txd == 1'b0) begin
        rx_busy = 1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == CPB / 2) begin
        check("rx_start", bus0.txd, 0);
      end else if (rx_cnt % CPB == CPB / 2
                   && rx_cnt < CPB * (DW + 1)) begin
        rx_word[rx_cnt/CPB-1] = bus0.txd;
      end else if (rx_cnt == CPB * (DW + 1) + CPB / 2) begin
        check("rx_stop", bus0.txd, 1);
        check("sb_avail", sb.size() > 0, 1);
        if (sb.size() > 0) check("rx_word", rx_word, sb.pop_front());
        rx_busy = 0;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_active || rx_busy) && k < budget) begin
      step(1);
      k++;
    end
    check("idle_timeout", m_active || rx_busy, 0);
  endtask

  int fd0;
  int np;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus0.enable     = 1'b0;
    bus1.enable     = 1'b0;
    bus1.fifo_empty = 1'b1;
    bus1.fifo_dout  = '0;
    fifo_drive();
    rst = 1'b1;
    step(3);
    check("rst0_txd", bus0.txd, 1);
    check("rst0_busy", bus0.busy, 0);
    check("rst1_txd", bus1.txd, 1);
    rst = 1'b0;
    step(2);

    // single word
    bus0.enable = 1'b1;
    fd0 = fd_cnt;
    push_word(16'hA5C3);
    step(2);
    wait_idle(200);
    check("t2_pops", pop_t.size(), 1);
    check("t2_fd", fd_cnt - fd0, 1);

    // three queued words back to back
    pop_t.delete();
    fd0 = fd_cnt;
    push_word(16'h1234);
    push_word(16'h8001);
    push_word(16'h7FFE);
    step(2);
    wait_idle(400);
    check("t3_pops", pop_t.size(), 3);
    for (int i = 1; i < 3; i++) begin
      if (i < pop_t.size())
        check("t3_gap", pop_t[i] - pop_t[i-1], F);
    end
    check("t3_fd", fd_cnt - fd0, 3);
    check("t3_txd_idle", bus0.txd, 1);

    // enable gating
    pop_t.delete();
    bus0.enable = 1'b0;
    push_word(16'h5A5A);
    step(50);
    check("t4_no_pop", pop_t.size(), 0);
    check("t4_txd", bus0.txd, 1);
    push_word(16'h0F0F);
    bus0.enable = 1'b1;
    step(30);
    bus0.enable = 1'b0;
    wait_idle(200);
    step(20);
    check("t4_pops", pop_t.size(), 1);
    check("t4_left", fq.size(), 1);
    bus0.enable = 1'b1;
    step(2);
    wait_idle(200);
    check("t4_drain", fq.size(), 0);

    // empty FIFO, then dout noise during a frame
    pop_t.delete();
    repeat (1000) begin
      junk = 16'($urandom);
      step(1);
    end
    check("t5_no_pop", pop_t.size(), 0);
    push_word(16'h3C96);
    repeat (80) begin
      step(1);
      junk = 16'($urandom);
    end
    wait_idle(100);
    check("t5_pops", pop_t.size(), 1);

    // reset mid-DATA with another word waiting
    pop_t.delete();
    fd0 = fd_cnt;
    push_word(16'h1357);
    step(2);
    np = 0;
    while (m_active && m_cnt < 20 && np < 100) begin
      step(1);
      np++;
    end
    check("t1_mid", m_cnt >= 20, 1);
    push_word(16'h2468);
    rst = 1'b1;
    #1;
    check("t1_txd", bus0.txd, 1);
    check("t1_busy", bus0.busy, 0);
    check("t1_rd", bus0.fifo_rd, 0);
    step(5);
    check("t1_no_pop", pop_t.size(), 1);
    rst = 1'b0;
    step(2);
    wait_idle(200);
    check("t1_pops", pop_t.size(), 2);
    check("t1_fd", fd_cnt - fd0, 1);

    // second config: 2 clks/bit, 2 stop bits
    bus1.enable     = 1'b1;
    bus1.fifo_dout  = 16'hFFFF;
    bus1.fifo_empty = 1'b0;
    #1;
    check("t6_rd", bus1.fifo_rd, 1);
    @(posedge clk);
    #1;
    bus1.fifo_empty = 1'b1;
    bus1.fifo_dout  = '0;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      check("t6_txd", bus1.txd, (c <= 2) ? 0 : 1);
      check("t6_busy", bus1.busy, 1);
      check("t6_fd", bus1.frame_done, (c == 38));
      check("t6_rd_once", bus1.fifo_rd, 0);
    end
    @(negedge clk);
    check("t6_end_busy", bus1.busy, 0);
    check("t6_end_fd", bus1.frame_done, 0);
    check("t6_end_txd", bus1.txd, 1);

    step(2);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
